// File: rtl/reg16_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg16_write_arbiter
//   Round-robin write arbiter in front of a shared load-enabled register.
//   Each requester presents a data word and a request. One requester is granted
//   per load cycle, and the arbiter drives the register's ld/in pins.
//   All outputs come straight from flops.
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous, active-high reset
//   req     per-requester request, held until the matching gnt bit is seen
//   wdata   requester i data at [i*WIDTH +: WIDTH]
//   lock    per-requester burst-hold request (REG_ARB_LOCK_EN builds only)
//   gnt     one-hot grant, high during the load cycle
//   reg_ld  register load enable (high exactly when gnt != 0)
//   reg_in  register data input
//   busy    high whenever the arbiter is not idle
//
// Build option
//   REG_ARB_LOCK_EN : adds the lock port. A winner that holds its lock bit keeps
//                     the grant for up to MAX_LOCK consecutive load cycles.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant outstanding; gnt/reg_ld/reg_in are zero
// LOAD  | one requester granted; the register captures reg_in at the next edge
// -----------------------------------------------------------------------------
module reg16_write_arbiter #(
    parameter int WIDTH    = 16,
    parameter int NUM_REQ  = 4,
    parameter int MAX_LOCK = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] wdata,
`ifdef REG_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]       lock,
`endif
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     reg_ld,
    output logic [WIDTH-1:0]         reg_in,
    output logic                     busy
);

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("reg16_write_arbiter: NUM_REQ must be in 2..8");
    end
    if (MAX_LOCK < 1) begin : g_bad_max_lock
        $error("reg16_write_arbiter: MAX_LOCK must be at least 1");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 reg_ld_q, reg_ld_d;
    logic [WIDTH-1:0]     reg_in_q, reg_in_d;
    logic [IW-1:0]        rr_q, rr_d;
    logic [IW-1:0]        win_q, win_d;

`ifdef REG_ARB_LOCK_EN
    localparam int CW = $clog2(MAX_LOCK + 1);
    logic [CW-1:0]        cnt_q, cnt_d;
`endif

    logic [NUM_REQ-1:0]   scan_cand;
    logic [IW-1:0]        scan_start;
    logic [IW-1:0]        scan_idx;
    logic                 pick_found;
    logic [IW-1:0]        pick_idx;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
        if (idx == IW'(NUM_REQ - 1)) begin
            return '0;
        end
        return idx + IW'(1);
    endfunction

    function automatic logic [WIDTH-1:0] word_of(input logic [NUM_REQ*WIDTH-1:0] bus,
                                                 input logic [IW-1:0]            idx);
        logic [WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx == IW'(i)) begin
                w = bus[i*WIDTH +: WIDTH];
            end
        end
        return w;
    endfunction

    // Candidate scan. In LOAD the current winner's req is still high and must be
    // masked; the scan starts just past it, which is where rr_ptr will land.
    always_comb begin
        scan_cand  = req & ~gnt_q;
        scan_start = (state_q == ST_LOAD) ? wrap_inc(win_q) : rr_q;
        scan_idx   = scan_start;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_found && scan_cand[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
            scan_idx = wrap_inc(scan_idx);
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        reg_ld_d = reg_ld_q;
        reg_in_d = reg_in_q;
        rr_d     = rr_q;
        win_d    = win_q;
`ifdef REG_ARB_LOCK_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d  = ST_LOAD;
                    win_d    = pick_idx;
                    gnt_d    = NUM_REQ'(1) << pick_idx;
                    reg_ld_d = 1'b1;
                    reg_in_d = word_of(wdata, pick_idx);
`ifdef REG_ARB_LOCK_EN
                    cnt_d    = CW'(1);
`endif
                end
            end
            ST_LOAD: begin
`ifdef REG_ARB_LOCK_EN
                if (lock[win_q] && (cnt_q < CW'(MAX_LOCK))) begin
                    // Held burst: same winner, fresh data, rr_ptr untouched.
                    reg_in_d = word_of(wdata, win_q);
                    cnt_d    = cnt_q + CW'(1);
                end else
`endif
                begin
                    rr_d = wrap_inc(win_q);
                    if (pick_found) begin
                        win_d    = pick_idx;
                        gnt_d    = NUM_REQ'(1) << pick_idx;
                        reg_ld_d = 1'b1;
                        reg_in_d = word_of(wdata, pick_idx);
`ifdef REG_ARB_LOCK_EN
                        cnt_d    = CW'(1);
`endif
                    end else begin
                        state_d  = ST_IDLE;
                        gnt_d    = '0;
                        reg_ld_d = 1'b0;
                        reg_in_d = '0;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                gnt_d    = '0;
                reg_ld_d = 1'b0;
                reg_in_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            reg_ld_q <= 1'b0;
            reg_in_q <= '0;
            rr_q     <= '0;
            win_q    <= '0;
`ifdef REG_ARB_LOCK_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            reg_ld_q <= reg_ld_d;
            reg_in_q <= reg_in_d;
            rr_q     <= rr_d;
            win_q    <= win_d;
`ifdef REG_ARB_LOCK_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign gnt    = gnt_q;
    assign reg_ld = reg_ld_q;
    assign reg_in = reg_in_q;
    assign busy   = (state_q == ST_LOAD);

endmodule

// File: tb/tb_reg16_write_arbiter.sv
// Testbench for reg16_write_arbiter: directed scenarios followed by random
// request/data traffic, all checked against a round-robin reference model.
module tb_reg16_write_arbiter;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] wdata = '0;
`ifdef REG_ARB_LOCK_EN
    logic [N-1:0]   lock = '0;
`endif
    logic [N-1:0]   gnt;
    logic           reg_ld;
    logic [W-1:0]   reg_in;
    logic           busy;

    reg16_write_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_LOCK(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .wdata  (wdata),
`ifdef REG_ARB_LOCK_EN
        .lock   (lock),
`endif
        .gnt    (gnt),
        .reg_ld (reg_ld),
        .reg_in (reg_in),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // The shared register sitting behind the arbiter.
    logic [W-1:0] reg_q = '0;
    always @(posedge clk) if (reg_ld) reg_q <= reg_in;

    // Reference model: index of the requester being loaded (-1 when idle).
    int           m_win = -1;
    int           m_rr  = 0;
    logic [W-1:0] m_in  = '0;
    logic [W-1:0] m_q   = '0;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_win = -1;
        m_rr  = 0;
        m_in  = '0;
    endtask

    // One clock edge of the arbitration rules, using the inputs held before it.
    task automatic model_edge();
        logic [N-1:0] cand;
        int w;
        if (m_win >= 0) m_q = m_in;
        cand = req;
        if (m_win >= 0) begin
            m_rr = (m_win + 1) % N;
            cand[m_win] = 1'b0;
        end
        w = -1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && cand[(m_rr + k) % N]) w = (m_rr + k) % N;
        end
        m_win = w;
        m_in  = (w >= 0) ? wdata[w*W +: W] : '0;
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] eg;
        eg = '0;
        if (m_win >= 0) eg[m_win] = 1'b1;
        chk({tag, ".gnt"},    32'(gnt),    32'(eg));
        chk({tag, ".reg_ld"}, 32'(reg_ld), 32'(m_win >= 0));
        chk({tag, ".reg_in"}, 32'(reg_in), 32'(m_in));
        chk({tag, ".busy"},   32'(busy),   32'(m_win >= 0));
        chk({tag, ".q"},      32'(reg_q),  32'(m_q));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Called 1 time unit after an edge (or at time 0); ends 2 units after an edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("rst");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        // Test 1: single request from requester 1.
        do_reset();
        req = 4'b0010;
        wdata[1*W +: W] = 16'hBEEF;
        step("t1.grant");
        chk("t1.gnt_const", 32'(gnt), 32'h2);
        chk("t1.in_const", 32'(reg_in), 32'hBEEF);
        req = '0;
        step("t1.done");
        chk("t1.q_const", 32'(reg_q), 32'hBEEF);
        chk("t1.busy_const", 32'(busy), 32'h0);

        // Test 2: all requesting continuously.
        do_reset();
        for (int i = 0; i < N; i++) wdata[i*W +: W] = 16'(i);
        req = 4'b1111;
        step("t2.c0");
        chk("t2.first_gnt", 32'(gnt), 32'h1);
        repeat (8) step("t2");
        req = '0;
        step("t2.drain");

        // Test 3: after a grant to 2, requester 3 outranks 0.
        do_reset();
        req = 4'b0100;
        step("t3.g2");
        req = 4'b1001;
        step("t3.g3");
        chk("t3.gnt_const", 32'(gnt), 32'h8);
        req = 4'b0001;
        step("t3.g0");
        req = '0;
        step("t3.idle");

        // Test 4: asynchronous reset in the middle of a load.
        do_reset();
        req = 4'b0100;
        step("t4.grant");
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("t4.async");
        chk("t4.ld_const", 32'(reg_ld), 32'h0);
        #1 rst = 1'b0;
        req = 4'b1111;
        step("t4.after");
        chk("t4.gnt_const", 32'(gnt), 32'h1);
        req = '0;
        step("t4.idle");

        // Test 6: quiet after reset.
        do_reset();
        req = '0;
        repeat (20) step("t6");

        // Random traffic with occasional resets.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 63) == 0) do_reset();
            req = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) wdata[i*W +: W] = 16'($urandom);
            step("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
